// File: rtl/shape_pkg.sv
// Shared shape/area types for the area scheduler: a shape is a kind plus two
// 18-bit dimensions, and an area result is the full-width 36-bit product.
package shape_pkg;

    localparam int KIND_W  = 3;
    localparam int DIM_W   = 18;
    localparam int SHAPE_W = KIND_W + 2 * DIM_W;
    localparam int AREA_W  = 2 * DIM_W;

    typedef enum logic [KIND_W-1:0] {
        SHAPE_RECT    = 3'd0,
        SHAPE_TRI     = 3'd1,
        SHAPE_ELLIPSE = 3'd2
    } shape_kind_e;

    typedef struct packed {
        shape_kind_e        kind;
        logic [DIM_W-1:0]   width;
        logic [DIM_W-1:0]   height;
    } shape_t;

    typedef logic [AREA_W-1:0] area_t;

    // Bounding-box area; the product of two DIM_W values always fits in AREA_W.
    function automatic area_t rect_area(input shape_t s);
        return area_t'(s.width) * area_t'(s.height);
    endfunction

endpackage

// File: rtl/shape_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every shape issued to the
// datapath; DEPTH must be a power of two so the pointers wrap for free.
module shape_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign count     = cnt_q;
    assign head_data = mem_q[rd_q];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shape_area_scheduler.sv
// Round-robin arbiter feeding one shared area-compute datapath, with an
// in-order tag FIFO that routes each returning area back to its requester.
module shape_area_scheduler
    import shape_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic   [NUM_REQ-1:0]           req_valid,
    output logic   [NUM_REQ-1:0]           req_ready,
    input  shape_t [NUM_REQ-1:0]           req_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output shape_t                         out_data,
    input  logic                           area_valid,
    output logic                           area_ready,
    input  area_t                          area_data,
    output logic   [NUM_REQ-1:0]           rsp_valid,
    input  logic   [NUM_REQ-1:0]           rsp_ready,
    output area_t                          rsp_data,
    output logic   [$clog2(TAG_DEPTH+1)-1:0] inflight,
    output logic                           err_orphan
);

    // Every valid/ready pair transfers only on a rising edge where both are high;
    // valid never waits on ready, and a held out_valid/out_data stays stable.
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] head_id;
    logic            found;
    logic            can_issue;
    logic            grant;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            out_valid_q, out_valid_d;
    shape_t          out_data_q, out_data_d;
    logic            err_orphan_q, err_orphan_d;
    logic [CNT_W-1:0] fifo_count;

    // Circular search from the pointer; the first valid requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                winner = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot early.
    assign can_issue = rstn && (!out_valid_q || out_ready) && !fifo_full;
    assign grant     = found && can_issue;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (grant) begin
            ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[winner];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (area_valid && !fifo_empty) begin
            rsp_valid[head_id] = 1'b1;
        end
    end

    assign area_ready   = !fifo_empty && rsp_ready[head_id];
    assign pop          = area_valid && area_ready;
    assign rsp_data     = area_data;
    assign err_orphan_d = err_orphan_q || (area_valid && fifo_empty);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    shape_tag_fifo #(
        .W     (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (grant),
        .push_data (winner),
        .pop       (pop),
        .head_data (head_id),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign inflight   = fifo_count;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_shape_area_scheduler.sv
// Bench for shape_area_scheduler: inputs change 1 time unit after the rising
// edge, outputs are observed on the falling edge.
module tb_shape_area_scheduler;
    import shape_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int TAG_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NUM_REQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    shape_t [NUM_REQ-1:0] req_data;
    logic                 out_valid, out_ready;
    shape_t               out_data;
    logic                 area_valid, area_ready;
    area_t                area_data, rsp_data;
    logic [2:0]           inflight;
    logic                 err_orphan;

    int checks = 0;
    int errors = 0;
    logic [2+AREA_W-1:0] exp_q[$];

    shape_area_scheduler #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .area_valid(area_valid), .area_ready(area_ready), .area_data(area_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    function automatic shape_t rand_shape();
        shape_t s;
        s.kind   = shape_kind_e'(3'($urandom_range(0, 2)));
        s.width  = DIM_W'($urandom_range(1, 262143));
        s.height = DIM_W'($urandom_range(1, 262143));
        return s;
    endfunction

    function automatic logic [1:0] oh_idx(input logic [3:0] v);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic apply_reset();
        rstn = 1'b0; req_valid = '0; out_ready = 1'b0; area_valid = 1'b0;
        area_data = '0; rsp_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = rand_shape();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = '1; out_ready = 1'b1; rsp_ready = '1;
        area_valid = 1'b0; area_data = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = rand_shape();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got %b exp 0", err_orphan); end
        checks++; if (area_ready !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_area_rsp got %b/%b exp 0/0000", area_ready, rsp_valid); end
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
    endtask

    task automatic test_loopback();
        area_t        dp_a[$];
        int           dp_due[$];
        logic [1:0]   grant_q[$];
        logic [1:0]   g_exp;
        logic [2+AREA_W-1:0] e, got;
        int           grants = 0;
        logic         afire;
        apply_reset();
        for (int g = 0; g < 12; g++) begin
            grant_q.push_back(2'(g % 4));
            exp_q.push_back({2'(g % 4), rect_area(req_data[g % 4])});
        end
        req_valid = '1; out_ready = 1'b1; rsp_ready = '1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                g_exp = (grant_q.size() > 0) ? grant_q.pop_front() : 2'd0;
                checks++; if (req_ready !== (4'b0001 << g_exp)) begin errors++; $display("FAIL loop_grant got %b exp %b", req_ready, 4'b0001 << g_exp); end
                grants++;
            end
            if (out_valid && out_ready) begin
                dp_a.push_back(rect_area(out_data));
                dp_due.push_back(c + 2);
            end
            afire = area_valid && area_ready;
            if (|(rsp_valid & rsp_ready)) begin
                e   = exp_q.pop_front();
                got = {oh_idx(rsp_valid), rsp_data};
                checks++; if (got !== e || !$onehot(rsp_valid)) begin errors++; $display("FAIL loop_rsp got %b/%0h exp id %0d/%0h", rsp_valid, rsp_data, e[AREA_W+:2], e[AREA_W-1:0]); end
            end
            @(posedge clk); #1;
            if (afire && dp_a.size() > 0) begin
                void'(dp_a.pop_front());
                void'(dp_due.pop_front());
            end
            if (grants >= 12) req_valid = '0;
            area_valid = (dp_a.size() > 0) && (dp_due[0] <= c + 1);
            area_data  = (dp_a.size() > 0) ? dp_a[0] : '0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loop_timeout got %0d pending exp 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_single();
        shape_t s;
        apply_reset();
        s = shape_t'(39'h00DEADBEEF);
        req_data[2] = s; req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== s) begin errors++; $display("FAIL single_out_data got %h exp %h", out_data, s); end
        checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL single_inflight got %0d exp 1", inflight); end
        @(posedge clk); #1 req_valid = '1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL single_ptr_next got %b exp 1000", req_ready); end
    endtask

    task automatic test_stall();
        apply_reset();
        req_valid = '1; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_first got %b exp 0001", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== req_data[0]) begin errors++; $display("FAIL stall_hold got %b/%h exp 1/%h", out_valid, out_data, req_data[0]); end
            checks++; if (req_ready !== 4'b0000 || inflight !== 3'd1) begin errors++; $display("FAIL stall_block got %b/%0d exp 0000/1", req_ready, inflight); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_release got %b exp 0010", req_ready); end
    endtask

    task automatic test_full();
        int pend[4] = '{2, 2, 1, 1};
        int ngrant = 0;
        area_t a;
        apply_reset();
        out_ready = 1'b1; rsp_ready = '1;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                ngrant++;
                pend[oh_idx(req_ready)]--;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) req_valid[i] = (pend[i] > 0);
        end
        @(negedge clk);
        checks++; if (ngrant != 4) begin errors++; $display("FAIL full_grants got %0d exp 4", ngrant); end
        checks++; if (inflight !== 3'd4 || req_ready !== 4'b0000) begin errors++; $display("FAIL full_block got %0d/%b exp 4/0000", inflight, req_ready); end
        @(posedge clk); #1;
        a = area_t'({$urandom(), $urandom()}); area_valid = 1'b1; area_data = a;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0001 || area_ready !== 1'b1) begin errors++; $display("FAIL full_pop got %b/%b exp 0001/1", rsp_valid, area_ready); end
        checks++; if (rsp_data !== a) begin errors++; $display("FAIL full_rsp_data got %h exp %h", rsp_data, a); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_no_early got %b exp 0000", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (inflight !== 3'd3 || req_ready !== 4'b0001 || rsp_valid !== 4'b0010) begin errors++; $display("FAIL full_pushpop got %0d/%b/%b exp 3/0001/0010", inflight, req_ready, rsp_valid); end
        @(posedge clk); #1 area_valid = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL full_level got %0d exp 3", inflight); end
    endtask

    task automatic test_orphan();
        apply_reset();
        area_valid = 1'b1; rsp_ready = '1; area_data = area_t'(36'h123456789);
        @(negedge clk);
        checks++; if (area_ready !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL orphan_block got %b/%b exp 0/0000", area_ready, rsp_valid); end
        @(posedge clk); #1 area_valid = 1'b0;
        @(negedge clk);
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b exp 0", err_orphan); end
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = '1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (inflight !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b exp 3/1", inflight, out_valid); end
        #2 rstn = 1'b0; req_valid = '1; area_valid = 1'b1; rsp_ready = '1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== shape_t'('0)) begin errors++; $display("FAIL mid_out got %b/%h exp 0/0", out_valid, out_data); end
        checks++; if (inflight !== 3'd0 || err_orphan !== 1'b0) begin errors++; $display("FAIL mid_state got %0d/%b exp 0/0", inflight, err_orphan); end
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || area_ready !== 1'b0) begin errors++; $display("FAIL mid_hs got %b/%b/%b exp 0000/0000/0", req_ready, rsp_valid, area_ready); end
        area_valid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_single();
        test_stall();
        test_full();
        test_orphan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
